// File: rtl/traffic_phase_sched.sv
// Highway / country-road crossing controller with programmable dwell times.
// Optional pedestrian walk phase is compiled in when PED_WALK_EN is defined.
module traffic_phase_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_sense,
    input  logic       ped_req,
    input  logic       ld_en,
    input  logic [1:0] ld_sel,
    input  logic [7:0] ld_val,
    output logic [2:0] highGYR,
    output logic [2:0] counGYR,
    output logic       walk,
    output logic [2:0] phase,
    output logic       cycle_done
);

    typedef enum logic [2:0] {
        S0_HWY_GREEN = 3'd0,
        S1_HWY_YEL   = 3'd1,
        S2_ALL_RED_A = 3'd2,
        S3_CNT_GREEN = 3'd3,
        S4_CNT_YEL   = 3'd4,
        S5_ALL_RED_B = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_cnt;
    logic [7:0] r_tHmin;
    logic [7:0] r_tY;
    logic [7:0] r_tR;
    logic [7:0] r_tCmax;
    logic [2:0] r_highGYR;
    logic [2:0] r_counGYR;
    logic       r_walk;
    logic       r_cycleDone;
    logic       w_pedPend;
    logic       w_entering;
    logic [2:0] w_nextHigh;
    logic [2:0] w_nextCoun;
    logic       w_nextWalk;
    logic [7:0] w_hminM1;
    logic [7:0] w_yM1;
    logic [7:0] w_rM1;
    logic [7:0] w_cmaxM1;

    // A programmed zero behaves like one, so the last dwell count is never below 0.
    function automatic logic [7:0] lastCount(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : (v - 8'd1);
    endfunction

    assign w_hminM1   = lastCount(r_tHmin);
    assign w_yM1      = lastCount(r_tY);
    assign w_rM1      = lastCount(r_tR);
    assign w_cmaxM1   = lastCount(r_tCmax);
    assign w_entering = (w_nextState != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tHmin <= 8'd20;
            r_tY    <= 8'd4;
            r_tR    <= 8'd2;
            r_tCmax <= 8'd15;
        end else if (ld_en) begin
            case (ld_sel)
                2'd0:    r_tHmin <= ld_val;
                2'd1:    r_tY    <= ld_val;
                2'd2:    r_tR    <= ld_val;
                default: r_tCmax <= ld_val;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0_HWY_GREEN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_entering) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S0_HWY_GREEN: if ((car_sense || w_pedPend) && (r_cnt >= w_hminM1)) w_nextState = S1_HWY_YEL;
            S1_HWY_YEL:   if (r_cnt == w_yM1) w_nextState = S2_ALL_RED_A;
            S2_ALL_RED_A: if (r_cnt == w_rM1) w_nextState = S3_CNT_GREEN;
            S3_CNT_GREEN: if ((r_cnt == w_cmaxM1) || (!car_sense && !r_walk)) w_nextState = S4_CNT_YEL;
            S4_CNT_YEL:   if (r_cnt == w_yM1) w_nextState = S5_ALL_RED_B;
            S5_ALL_RED_B: if (r_cnt == w_rM1) w_nextState = S0_HWY_GREEN;
            default:      w_nextState = S0_HWY_GREEN;
        endcase
    end

    // Lamps are decoded from the next state so the registered outputs track the state register.
    always_comb begin
        w_nextHigh = 3'b001;
        w_nextCoun = 3'b001;
        case (w_nextState)
            S0_HWY_GREEN: w_nextHigh = 3'b100;
            S1_HWY_YEL:   w_nextHigh = 3'b010;
            S3_CNT_GREEN: w_nextCoun = 3'b100;
            S4_CNT_YEL:   w_nextCoun = 3'b010;
            default:      w_nextHigh = 3'b001;
        endcase
    end

`ifdef PED_WALK_EN
    logic r_pedPend;

    // A request on the S3 entry edge wins over the clear and is served next round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pedPend <= 1'b0;
        end else if (ped_req) begin
            r_pedPend <= 1'b1;
        end else if (w_entering && (w_nextState == S3_CNT_GREEN)) begin
            r_pedPend <= 1'b0;
        end
    end

    assign w_pedPend  = r_pedPend;
    assign w_nextWalk = (w_nextState == S3_CNT_GREEN) ? (w_entering ? r_pedPend : r_walk) : 1'b0;
`else
    assign w_pedPend  = ped_req & 1'b0;
    assign w_nextWalk = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_highGYR   <= 3'b100;
            r_counGYR   <= 3'b001;
            r_walk      <= 1'b0;
            r_cycleDone <= 1'b0;
        end else begin
            r_highGYR   <= w_nextHigh;
            r_counGYR   <= w_nextCoun;
            r_walk      <= w_nextWalk;
            r_cycleDone <= (r_state == S5_ALL_RED_B) && (w_nextState == S0_HWY_GREEN);
        end
    end

    assign highGYR    = r_highGYR;
    assign counGYR    = r_counGYR;
    assign walk       = r_walk;
    assign phase      = r_state;
    assign cycle_done = r_cycleDone;

endmodule

// File: doc/traffic_phase_sched.md
TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 car_sense  input  1  country-road vehicle detector, synchronous to clk.
REQ-004 ped_req  input  1  pedestrian button; pulse or level, sampled each cycle.
REQ-005 ld_en  input  1  timing-register write strobe.
REQ-006 ld_sel  input  2  target register: 0=T_HMIN, 1=T_Y, 2=T_R, 3=T_CMAX.
REQ-007 ld_val  input  8  value written when ld_en=1.
REQ-008 highGYR  output  3  highway lamps {G,Y,R}, one-hot, registered.
REQ-009 counGYR  output  3  country lamps {G,Y,R}, one-hot, registered.
REQ-010 walk  output  1  pedestrian walk lamp, registered.
REQ-011 phase  output  3  current state encoding (S0=0 ... S5=5).
REQ-012 cycle_done  output  1  one-cycle pulse on the S5->S0 transition.

Function
REQ-013 States and lamps (highGYR/counGYR): S0 HWY_GREEN 100/001; S1 HWY_YEL 010/001; S2 ALL_RED_A 001/001; S3 CNT_GREEN 001/100; S4 CNT_YEL 001/010; S5 ALL_RED_B 001/001.
REQ-014 Lamp outputs SHALL be a function of the current state only; never two greens, never green plus yellow on one road.
REQ-015 8-bit dwell counter cnt SHALL clear to 0 on every state entry and increment each cycle, saturating at 255.
REQ-016 S0->S1 when (car_sense=1 or ped_pend=1) and cnt >= T_HMIN-1; otherwise remain in S0 indefinitely.
REQ-017 S1->S2 when cnt = T_Y-1; S2->S3 when cnt = T_R-1; S4->S5 when cnt = T_Y-1; S5->S0 when cnt = T_R-1 (each state lasts exactly T_Y or T_R cycles).
REQ-018 S3->S4 when cnt = T_CMAX-1, or when car_sense=0 and walk=0, whichever comes first.
REQ-019 Timing register value 0 SHALL be treated as 1.
REQ-020 A timing-register write takes effect on the cycle after ld_en; a write during a state affects that state's comparison immediately.
REQ-021 ped_pend SHALL set on any cycle with ped_req=1 and clear on entry to S3; ped_req=1 on the S2->S3 edge sets ped_pend again (serviced next cycle round).
REQ-022 cycle_done SHALL be high exactly the first cycle in S0 after S5.

Reset
REQ-023 On rst=1, immediately: state S0, highGYR=100, counGYR=001, walk=0, phase=0, cycle_done=0, cnt=0, ped_pend=0.
REQ-024 Timing registers reset to T_HMIN=20, T_Y=4, T_R=2, T_CMAX=15.
REQ-025 rst asserted mid-phase (any state) SHALL abort the phase with no intermediate lamp state.

Configuration
REQ-026 Macro PED_WALK_EN: when defined, ped_pend, walk and REQ-021 logic are present; walk=1 throughout S3 entered with ped_pend=1, and S3 then dwells full T_CMAX.
REQ-027 Without PED_WALK_EN: ped_req ignored, ped_pend constant 0, walk tied 0; ports remain.

Verification
REQ-028 Reset, car_sense=1 held -> S0 20 cycles, S1 4, S2 2, then S3 with counGYR=100.
REQ-029 In S3 with defaults, drop car_sense at S3 cycle 5 -> S4 on next edge; S4 4 cycles, S5 2, S0 with cycle_done pulse one cycle.
REQ-030 car_sense=1 held through S3 -> S3 lasts exactly 15 cycles then S4.
REQ-031 PED_WALK_EN, car_sense=0, ped_req pulse at cycle 3 -> S1 at cycle 20, walk=1 for all 15 S3 cycles, ped_pend cleared.
REQ-032 Write ld_sel=1, ld_val=0 -> S1 and S4 last 1 cycle; write ld_sel=0, ld_val=3 during S0 with car_sense=1 -> exit S0 once cnt>=2.
REQ-033 Assert rst during S3 cycle 7 -> outputs 100/001, walk=0, phase=0 before next clk edge; sequence restarts at S0.
